// File: rtl/tls_pkg.sv
// rtl/tls_pkg.sv - shared types, defaults and helpers for the traffic phase controller
//
// Contents:
//   tls_state_t   : controller phase enumeration (IDLE, GREEN, YELLOW, ALLRED)
//   TLS_NDIR_DEF  : default number of conflicting approach directions
//   TLS_CW_DEF    : default width of durations and the phase counter
//   tls_clamp_dur : maps a zero duration to one so every phase is visible

package tls_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_ALLRED = 2'd3
   } tls_state_t;

   localparam int TLS_NDIR_DEF = 2;
   localparam int TLS_CW_DEF   = 4;

   // Generic 32-bit form; callers cast to their own counter width.
   function automatic logic [31:0] tls_clamp_dur(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/tls_down_counter.sv
// rtl/tls_down_counter.sv - phase down-counter with load, enable and expiry at one
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears count)
//   load       : load load_val (has priority over en)
//   load_val   : value loaded on load
//   en         : decrement when count is above one; otherwise hold
//   count      : current counter value
//   expire     : high while count equals one (last cycle of the phase)

module tls_down_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          expire
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count > CW'(1))) begin
         count <= count - CW'(1);
      end
   end

   assign expire = (count == CW'(1));

endmodule

// File: rtl/tls_phase_ctrl.sv
// rtl/tls_phase_ctrl.sv - round-robin traffic light phase controller
//
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   set           : latch gin/yin/rin and restart at direction 0 green (ignored if all zero)
//   stop          : freeze phase state and counter while high
//   jump          : abort green/yellow straight to all-red clearance
//   gin, yin, rin : green, yellow and all-red durations in cycles
//   gout, yout    : per-direction green / yellow lamp drives
//   rout          : per-direction red lamp drives
//   dir           : index of the active direction
//   remain        : cycles left in the current phase (0 in IDLE)

module tls_phase_ctrl
   import tls_pkg::*;
#(
   parameter int NDIR = TLS_NDIR_DEF,
   parameter int CW   = TLS_CW_DEF,
   localparam int DW  = (NDIR > 1) ? $clog2(NDIR) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            set,
   input  logic            stop,
   input  logic            jump,
   input  logic [CW-1:0]   gin,
   input  logic [CW-1:0]   yin,
   input  logic [CW-1:0]   rin,
   output logic [NDIR-1:0] gout,
   output logic [NDIR-1:0] yout,
   output logic [NDIR-1:0] rout,
   output logic [DW-1:0]   dir,
   output logic [CW-1:0]   remain
);

   tls_state_t    state_q, state_d;
   logic [DW-1:0] dir_q, dir_d;
   logic [CW-1:0] g_mem, y_mem, r_mem;

   logic          set_ok;
   logic [CW-1:0] gin_c, yin_c, rin_c;

   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_en;
   logic [CW-1:0] cnt_q;
   logic          cnt_expire;

   logic [NDIR-1:0] dir_onehot;

   // A set carrying only zero durations is treated as noise.
   assign set_ok = set && ((gin | yin | rin) != '0);

   // Clamping at latch time keeps the stored durations always >= 1.
   assign gin_c = CW'(tls_clamp_dur(32'(gin)));
   assign yin_c = CW'(tls_clamp_dur(32'(yin)));
   assign rin_c = CW'(tls_clamp_dur(32'(rin)));

   tls_down_counter #(
      .CW (CW)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .count    (cnt_q),
      .expire   (cnt_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         g_mem <= '0;
         y_mem <= '0;
         r_mem <= '0;
      end else if (set_ok) begin
         g_mem <= gin_c;
         y_mem <= yin_c;
         r_mem <= rin_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dir_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
      end
   end

   // Priority: set > jump > stop > normal count.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cnt_load = 1'b0;
      cnt_val  = g_mem;
      cnt_en   = 1'b0;

      if (set_ok) begin
         // Use the incoming duration directly; g_mem updates on the same edge.
         state_d  = ST_GREEN;
         dir_d    = '0;
         cnt_load = 1'b1;
         cnt_val  = gin_c;
      end else if (jump && ((state_q == ST_GREEN) || (state_q == ST_YELLOW))) begin
         state_d  = ST_ALLRED;
         cnt_load = 1'b1;
         cnt_val  = r_mem;
      end else if (!stop && (state_q != ST_IDLE)) begin
         if (cnt_expire) begin
            case (state_q)
               ST_GREEN: begin
                  state_d  = ST_YELLOW;
                  cnt_load = 1'b1;
                  cnt_val  = y_mem;
               end
               ST_YELLOW: begin
                  state_d  = ST_ALLRED;
                  cnt_load = 1'b1;
                  cnt_val  = r_mem;
               end
               ST_ALLRED: begin
                  // The only place the direction advances.
                  state_d  = ST_GREEN;
                  dir_d    = (dir_q == DW'(NDIR - 1)) ? '0 : dir_q + DW'(1);
                  cnt_load = 1'b1;
                  cnt_val  = g_mem;
               end
               default: begin
               end
            endcase
         end else begin
            cnt_en = 1'b1;
         end
      end
   end

   assign dir_onehot = NDIR'(1) << dir_q;

   // Lamp decode from registered state only.
   always_comb begin
      gout = '0;
      yout = '0;
      rout = '0;
      case (state_q)
         ST_GREEN: begin
            gout = dir_onehot;
            rout = ~dir_onehot;
         end
         ST_YELLOW: begin
            yout = dir_onehot;
            rout = ~dir_onehot;
         end
         ST_ALLRED: begin
            rout = '1;
         end
         default: begin
         end
      endcase
   end

   assign dir    = dir_q;
   assign remain = (state_q == ST_IDLE) ? '0 : cnt_q;

endmodule

// File: tb/tb_tls_phase_ctrl.sv
// tb/tb_tls_phase_ctrl.sv - scoreboard bench for tls_phase_ctrl against a phase-schedule model

module tb_tls_phase_ctrl;

   localparam int NDIR = 2;
   localparam int CW   = 4;

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic            set   = 1'b0;
   logic            stop  = 1'b0;
   logic            jump  = 1'b0;
   logic [CW-1:0]   gin   = '0;
   logic [CW-1:0]   yin   = '0;
   logic [CW-1:0]   rin   = '0;
   logic [NDIR-1:0] gout, yout, rout;
   logic [0:0]      dir;
   logic [CW-1:0]   remain;

   always #5 clk = ~clk;

   tls_phase_ctrl #(
      .NDIR (NDIR),
      .CW   (CW)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .set    (set),
      .stop   (stop),
      .jump   (jump),
      .gin    (gin),
      .yin    (yin),
      .rin    (rin),
      .gout   (gout),
      .yout   (yout),
      .rout   (rout),
      .dir    (dir),
      .remain (remain)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [NDIR-1:0] g;
      logic [NDIR-1:0] y;
      logic [NDIR-1:0] r;
      logic [0:0]      d;
      logic [CW-1:0]   rem;
   } exp_t;

   exp_t exp_q[$];

   // Model: phase 0 idle, 1 green, 2 yellow, 3 all-red; time spent counted upward.
   int m_ph  = 0;
   int m_dir = 0;
   int m_el  = 0;
   int m_dur[4] = '{0, 0, 0, 0};

   function automatic int clampi(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int m_remain();
      return (m_ph == 0) ? 0 : (m_dur[m_ph] - m_el);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic [NDIR-1:0] oh;
      oh = '0;
      oh[m_dir] = 1'b1;
      e.g   = (m_ph == 1) ? oh : '0;
      e.y   = (m_ph == 2) ? oh : '0;
      e.r   = (m_ph == 3) ? '1 : ((m_ph == 1) || (m_ph == 2)) ? ~oh : '0;
      e.d   = 1'(m_dir);
      e.rem = CW'(m_remain());
      return e;
   endfunction

   task automatic model_step(input bit r, input bit s, input bit j, input bit p,
                             input int g, input int y, input int rr);
      if (r) begin
         m_ph = 0; m_dir = 0; m_el = 0;
         m_dur = '{0, 0, 0, 0};
      end else if (s && ((g != 0) || (y != 0) || (rr != 0))) begin
         m_dur[1] = clampi(g);
         m_dur[2] = clampi(y);
         m_dur[3] = clampi(rr);
         m_ph = 1; m_dir = 0; m_el = 0;
      end else if (j && ((m_ph == 1) || (m_ph == 2))) begin
         m_ph = 3; m_el = 0;
      end else if (p || (m_ph == 0)) begin
         // frozen or idle
      end else begin
         m_el++;
         if (m_el == m_dur[m_ph]) begin
            m_el = 0;
            if (m_ph == 3) begin
               m_ph  = 1;
               m_dir = (m_dir + 1) % NDIR;
            end else begin
               m_ph++;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // One stimulus cycle: drive at negedge, push the outputs expected after the next edge.
   task automatic cyc(input bit r, input bit s, input bit j, input bit p,
                      input int g, input int y, input int rr);
      @(negedge clk);
      reset = r; set = s; jump = j; stop = p;
      gin = CW'(g); yin = CW'(y); rin = CW'(rr);
      model_step(r, s, j, p, g, y, rr);
      exp_q.push_back(model_out());
      if (r) begin
         #1;
         chk("async_reset_lamps", 32'({gout, yout, rout}), 32'd0);
         chk("async_reset_remain", 32'(remain), 32'd0);
      end
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_until(input int ph, input int d, input int rem, input int budget,
                            input string tag);
      int  n;
      bit  hit;
      n = 0;
      hit = (m_ph == ph) && (m_dir == d) && ((rem < 0) || (m_remain() == rem));
      while (!hit && (n < budget)) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         n++;
         hit = (m_ph == ph) && (m_dir == d) && ((rem < 0) || (m_remain() == rem));
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL reach_%s: got no match after %0d cycles expected phase %0d dir %0d",
                  tag, n, ph, d);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare one scoreboard entry per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gout",   32'(gout),   32'(e.g));
            chk("yout",   32'(yout),   32'(e.y));
            chk("rout",   32'(rout),   32'(e.r));
            chk("dir",    32'(dir),    32'(e.d));
            chk("remain", 32'(remain), 32'(e.rem));
         end
      end
   end

   initial begin
      #1;
      chk("reset_lamps", 32'({gout, yout, rout}), 32'd0);
      chk("reset_remain", 32'(remain), 32'd0);
      chk("reset_dir", 32'(dir), 32'd0);

      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle_n(3);
      cyc(0, 1, 0, 0, 0, 0, 0);          // all-zero set ignored
      cyc(0, 0, 1, 1, 0, 0, 0);          // jump/stop in idle ignored
      idle_n(2);

      cyc(0, 1, 0, 0, 3, 2, 1);          // basic 3/2/1 sequence
      idle_n(14);

      run_until(1, 0, 2, 30, "g0_rem2");
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
      idle_n(3);

      run_until(1, 1, 3, 30, "g1_rem3");
      cyc(0, 0, 1, 0, 0, 0, 0);          // jump to all-red
      idle_n(4);

      run_until(2, 1, -1, 30, "y1");
      cyc(0, 1, 0, 0, 5, 1, 2);          // restart with 5/1/2
      idle_n(20);

      run_until(2, 0, -1, 30, "y0");
      cyc(1, 0, 0, 0, 0, 0, 0);          // reset mid-yellow
      idle_n(4);
      cyc(0, 1, 0, 0, 2, 0, 0);          // zero yellow/red clamp to one
      idle_n(10);

      for (int i = 0; i < 1500; i++) begin
         bit r, s, j, p;
         int g, y, rr;
         r  = ($urandom_range(0, 299) == 0);
         s  = ($urandom_range(0, 39) == 0);
         j  = ($urandom_range(0, 19) == 0);
         p  = ($urandom_range(0, 4) == 0);
         g  = $urandom_range(0, 5);
         y  = $urandom_range(0, 5);
         rr = $urandom_range(0, 5);
         if ($urandom_range(0, 3) == 0) begin
            g = 0; y = 0; rr = 0;
         end
         cyc(r, s, j, p, g, y, rr);
      end

      @(negedge clk);
      reset = 1'b0; set = 1'b0; jump = 1'b0; stop = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tls_phase_ctrl.md
TLS_PHASE_CTRL -- requirements
Module: tls_phase_ctrl

Interface
REQ-001 The block SHALL have parameter NDIR, default 2, giving the number of conflicting approach directions (2..8) served in round-robin order.
REQ-002 The block SHALL have parameter CW, default 4, giving the width of the duration inputs and the phase counter.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port set, input, 1 bit: latch new durations and restart the sequence at direction 0 green.
REQ-006 The block SHALL have port stop, input, 1 bit: freeze the phase counter and state while high.
REQ-007 The block SHALL have port jump, input, 1 bit: abort the current green or yellow and go straight to all-red clearance.
REQ-008 The block SHALL have ports gin, yin and rin, each input, CW bits: green, yellow and all-red clearance durations in cycles.
REQ-009 The block SHALL have ports gout, yout and rout, each output, NDIR bits: per-direction lamp drives.
REQ-010 The block SHALL have port dir, output, clog2(NDIR) bits (minimum 1): index of the active direction.
REQ-011 The block SHALL have port remain, output, CW bits: the phase counter value, i.e. cycles left in the current phase.

Function
REQ-012 States SHALL be IDLE, GREEN, YELLOW and ALLRED, plus a registered direction index and a CW-bit down-counter.
REQ-013 Outputs SHALL be decoded only from registered state, with no combinational path from inputs to outputs.
- IDLE: all lamps 0.
- GREEN/YELLOW: gout[dir] or yout[dir] = 1; rout = 1 on every other direction.
- ALLRED: rout all ones.
REQ-014 Input priority each cycle SHALL be set > jump > stop > normal count.
REQ-015 When set is high and {gin,yin,rin} are not all zero, the block SHALL, in any state, latch gin/yin/rin into shadow registers and enter GREEN with dir = 0 and counter = gin, effective on the next edge.
REQ-016 A set with gin = yin = rin = 0 SHALL be ignored.
REQ-017 A latched duration of 0 SHALL be treated as 1, so every phase lasts at least one cycle.
REQ-018 Normal count: when the counter is greater than 1, the counter SHALL decrement by 1. When the counter equals 1, the state SHALL advance as follows:
- GREEN -> YELLOW, counter = y_mem.
- YELLOW -> ALLRED, counter = r_mem.
- ALLRED -> GREEN, dir = (dir + 1) mod NDIR, counter = g_mem.
REQ-019 As a result, a phase of duration D SHALL be displayed for exactly D cycles.
REQ-020 A jump in GREEN or YELLOW SHALL move the block to ALLRED with counter = r_mem, keeping dir unchanged.
REQ-021 A jump in ALLRED or IDLE SHALL be ignored.
REQ-022 A high stop SHALL hold state, dir and counter unchanged, with lamps steady; stop SHALL be ignored in IDLE.
REQ-023 Direction wrap from NDIR-1 to 0 SHALL occur only on ALLRED expiry.
REQ-024 Any set or reset SHALL restart the sequence at dir 0.
REQ-025 The block SHALL leave IDLE only via a valid set.
REQ-026 remain SHALL equal the counter value, and SHALL be 0 in IDLE.

Reset
REQ-027 Reset SHALL asynchronously force: state IDLE, dir 0, counter 0, shadow registers 0, gout/yout/rout all zero, remain 0, including mid-phase.
REQ-028 After reset deasserts, the block SHALL stay in IDLE until a valid set is sampled.

Structure
REQ-029 A shared package tls_pkg SHALL hold the state enumeration, the default NDIR/CW values and the duration-clamp helper (0 -> 1).
REQ-030 The counter SHALL be a sub-module tls_down_counter (CW-bit, load/enable/hold, expiry flag at value 1), instantiated once.

Verification (NDIR=2, CW=4)
REQ-031 Reset, then set with gin=3, yin=2, rin=1 -> the following sequence SHALL repeat:
- G0 for 3 cycles, Y0 for 2, all-red for 1.
- G1 for 3, Y1 for 2, all-red for 1.
- Back to G0, with the opposing rout high throughout.
REQ-032 stop held 4 cycles during G0 with remain=2 -> G0 SHALL last 7 cycles total and remain SHALL hold 2 while stop is high.
REQ-033 jump during G1 with remain=3 -> next cycle all-red for rin cycles, then G0 (dir wraps).
REQ-034 set with 5/1/2 during Y1 -> next cycle G0 with remain=5 and the new durations used thereafter.
REQ-035 In IDLE: set with all zero SHALL be ignored; set with gin=2, yin=0, rin=0 -> yellow and all-red SHALL each last 1 cycle.
REQ-036 Reset asserted mid-Y0 -> all lamps 0 immediately; after release the block SHALL stay in IDLE with no lamps until set.
